// File: rtl/imm_ext_pkg.sv
// Shared types for the pipelined immediate extender: extension modes and
// buffer occupancy states.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'd0,
    MODE_SIGN   = 2'd1,
    MODE_UPPER  = 2'd2,
    MODE_BRANCH = 2'd3
  } imm_mode_e;

  // Occupancy of the output + skid buffer pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender: zero, sign, upper (LUI-style)
// and branch-offset (sign-extend then shift left) modes.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]  data,
  input  imm_mode_e        mode,
  output logic [OUT_W-1:0] result
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] upper_ext;
  logic [OUT_W-1:0] branch_ext;

  assign zero_ext   = {{PAD_W{1'b0}}, data};
  assign sign_ext   = {{PAD_W{data[IN_W-1]}}, data};
  assign upper_ext  = {data, {PAD_W{1'b0}}};
  assign branch_ext = sign_ext << BR_SHIFT;

  always_comb begin
    // NOTE: default assignment first so every path drives result; no latch.
    result = zero_ext;
    unique case (mode)
      MODE_ZERO:   result = zero_ext;
      MODE_SIGN:   result = sign_ext;
      MODE_UPPER:  result = upper_ext;
      MODE_BRANCH: result = branch_ext;
      default:     result = zero_ext;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with valid/ready handshake and a 2-entry
// (output + skid) buffer. Define IMM_EXT_STATS_EN to add transfer/stall counters.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [IN_W-1:0]   data_i,
  input  logic [1:0]        mode_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [OUT_W-1:0]  data_o,
  output logic [1:0]        mode_o
`ifdef IMM_EXT_STATS_EN
  ,
  output logic [STAT_W-1:0] xfer_cnt_o,
  output logic [STAT_W-1:0] stall_cnt_o
`endif
);

  pipe_state_e      state_q, state_d;
  logic [OUT_W-1:0] ext_result;
  logic [OUT_W-1:0] out_d, sk_d;
  logic [1:0]       out_m, sk_m;
  logic             in_xfer, out_xfer;
  logic             load_out, load_sk, sk_to_out;

  imm_ext_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .BR_SHIFT(BR_SHIFT)
  ) u_core (
    .data  (data_i),
    .mode  (imm_mode_e'(mode_i)),
    .result(ext_result)
  );

  // Both flags decode straight from the state register: no ready_i -> ready_o path.
  assign valid_o  = (state_q != ST_EMPTY);
  assign ready_o  = (state_q != ST_FULL);
  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = valid_o && ready_i;
  assign data_o   = out_d;
  assign mode_o   = out_m;

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_sk   = 1'b0;
    sk_to_out = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          load_out = 1'b1;
          state_d  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_out = 1'b1;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end else if (in_xfer) begin
          load_sk = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          sk_to_out = 1'b1;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: non-blocking assignments for all registered state.
    if (!rst_i) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: the data registers are reset too, because data_o must read 0
    // during reset; without that they could stay reset-free.
    if (!rst_i) begin
      out_d <= '0;
      out_m <= '0;
      sk_d  <= '0;
      sk_m  <= '0;
    end else begin
      if (load_out) begin
        out_d <= ext_result;
        out_m <= mode_i;
      end else if (sk_to_out) begin
        out_d <= sk_d;
        out_m <= sk_m;
      end
      if (load_sk) begin
        sk_d <= ext_result;
        sk_m <= mode_i;
      end
    end
  end

`ifdef IMM_EXT_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      xfer_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (out_xfer) xfer_cnt_o <= xfer_cnt_o + STAT_W'(1);
      // Stall count saturates; the transfer count wraps.
      if (valid_o && !ready_i && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + STAT_W'(1);
    end
  end
`endif

endmodule
